// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory responder.
//   mem_size_e   : access width encoding carried on req_size
//   resp_state_e : responder FSM states
//   WAIT_W       : width of the wait-state counter (supports 0..15 wait states)
package riscv_mem_pkg;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL} mem_size_e;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_e;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit RAM word (combinational).
//   addr_lo       in  byte offset within the word
//   size          in  access width
//   load_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   wdata         in  right-aligned store data
//   old_word      in  current RAM word at the target index
//   wr_word       out old_word with the addressed lane(s) replaced by wdata
//   ld_data       out addressed lane(s) right-aligned and extended
//   misalign      out illegal size or address not aligned to the access width
module dmem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  mem_size_e   size,
   input  logic        load_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   output logic [31:0] wr_word,
   output logic [31:0] ld_data,
   output logic        misalign
);

   logic [31:0] shifted;

   // Right-align the addressed lane(s) so extension always starts at bit 0.
   assign shifted = old_word >> {addr_lo, 3'b000};

   always_comb begin
      misalign = 1'b0;
      wr_word  = old_word;
      ld_data  = 32'd0;
      unique case (size)
         SZ_BYTE: begin
            wr_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            ld_data = load_unsigned ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            misalign = addr_lo[0];
            wr_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            ld_data = load_unsigned ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
         end
         SZ_WORD: begin
            misalign = (addr_lo != 2'b00);
            wr_word  = wdata;
            ld_data  = old_word;
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// accesses an internal word RAM and returns the result on a valid/ready channel.
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_wren/addr/size/unsigned/wdata  request payload, sampled at accept only
//   resp_valid/resp_ready        response handshake
//   resp_rdata/resp_err          load data (0 for stores/errors), error flag
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wren,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << ADDR_W;

   resp_state_e       state;
   logic [WAIT_W-1:0] cnt;
   logic [31:0]       cap_addr, cap_wdata;
   mem_size_e         cap_size;
   logic              cap_unsigned, cap_wren;

   logic [31:0]       mem [DEPTH];

   logic [31:0]       cur_addr, cur_wdata, old_word, wr_word, ld_data, rdata_next;
   mem_size_e         cur_size;
   logic              cur_unsigned, cur_wren, misalign, oob, cur_err;
   logic              enter_resp, ram_we;
   logic [ADDR_W-1:0] cur_idx;

   // In IDLE the access may complete on the accept edge itself (no wait
   // states or an error), so the datapath looks at the live request there
   // and at the captured copy otherwise.
   always_comb begin
      if (state == IDLE) begin
         cur_addr     = req_addr;
         cur_size     = mem_size_e'(req_size);
         cur_unsigned = req_unsigned;
         cur_wren     = req_wren;
         cur_wdata    = req_wdata;
      end else begin
         cur_addr     = cap_addr;
         cur_size     = cap_size;
         cur_unsigned = cap_unsigned;
         cur_wren     = cap_wren;
         cur_wdata    = cap_wdata;
      end
   end

   assign cur_idx  = cur_addr[ADDR_W+1:2];
   assign old_word = mem[cur_idx];
   assign oob      = |(cur_addr >> (ADDR_W + 2));
   assign cur_err  = misalign | oob;

   dmem_lane_align u_align (
      .addr_lo       (cur_addr[1:0]),
      .size          (cur_size),
      .load_unsigned (cur_unsigned),
      .wdata         (cur_wdata),
      .old_word      (old_word),
      .wr_word       (wr_word),
      .ld_data       (ld_data),
      .misalign      (misalign)
   );

   assign enter_resp = ((state == IDLE) && req_valid && ((WAIT_CYCLES == 0) || cur_err))
                    || ((state == WAIT) && (cnt == '0));
   assign rdata_next = (cur_err || cur_wren) ? 32'd0 : ld_data;
   // reset_n gate keeps an edge that lands during reset from committing a store.
   assign ram_we     = reset_n && enter_resp && cur_wren && !cur_err;

   always_ff @(posedge clk) begin
      if (ram_we) mem[cur_idx] <= wr_word;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'd0;
         resp_err     <= 1'b0;
         cap_addr     <= 32'd0;
         cap_wdata    <= 32'd0;
         cap_size     <= SZ_BYTE;
         cap_unsigned <= 1'b0;
         cap_wren     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (req_valid) begin
               cap_addr     <= req_addr;
               cap_wdata    <= req_wdata;
               cap_size     <= mem_size_e'(req_size);
               cap_unsigned <= req_unsigned;
               cap_wren     <= req_wren;
               req_ready    <= 1'b0;
               if (enter_resp) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdata_next;
                  resp_err   <= cur_err;
               end else begin
                  state <= WAIT;
                  cnt   <= WAIT_W'(WAIT_CYCLES - 1);
               end
            end
            WAIT: begin
               if (enter_resp) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdata_next;
                  resp_err   <= cur_err;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
